// File: rtl/calc_entry_ctrl.sv
// Keypad calculator entry sequencer: operand/operator entry FSM, shift-add
// multiplier and display value selection.
module calc_entry_ctrl #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OPW        = 14,
  parameter int unsigned RW         = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    cursor_x,
  input  logic [3:0]    cursor_y,
  input  logic          btn_sel,
  input  logic          btn_op,
  output logic [RW-1:0] disp_value,
  output logic [1:0]    state,
  output logic [1:0]    op_code,
  output logic          busy,
  output logic          result_valid
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned MW = $clog2(OPW);
  localparam int unsigned XW = OPW + 4;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_CALC = 2'd2, S_RES = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d, mplier_q, mplier_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]      op_q, op_d;
  logic [RW-1:0]   res_q, res_d, acc_q, acc_d, mcand_q, mcand_d, disp_q, disp_d;
  logic [RW-1:0]   acc_step;
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic            sel_hist_q, op_hist_q, busy_q, rv_q;
  logic            sel_press, op_ev, key_valid, key_digit, key_clear, key_equals;
  logic [3:0]      dval;

  function automatic logic [OPW-1:0] push_digit(input logic [OPW-1:0] v, input logic [3:0] d);
    logic [XW-1:0] t;
    t = {4'd0, v} * XW'(10) + {{OPW{1'b0}}, d};
    return t[OPW-1:0];
  endfunction

  // Falling-edge press detection and key decode; a select press wins over operator.
  always_comb begin
    sel_press  = sel_hist_q & ~btn_sel;
    op_ev      = op_hist_q & ~btn_op & ~sel_press;
    key_valid  = (cursor_x <= 4'd2) && (cursor_y <= 4'd3);
    key_digit  = sel_press && key_valid && ((cursor_y <= 4'd2) || (cursor_x == 4'd1));
    key_clear  = sel_press && key_valid && (cursor_y == 4'd3) && (cursor_x == 4'd0);
    key_equals = sel_press && key_valid && (cursor_y == 4'd3) && (cursor_x == 4'd2);
    dval       = (cursor_y == 4'd3) ? 4'd0 : (cursor_y * 4'd3) + cursor_x + 4'd1;
    acc_step   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_d     = op_q;
    res_d    = res_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mcnt_d   = mcnt_q;
    disp_d   = disp_q;

    unique case (state_q)
      S_A: begin
        if (key_digit && (cnt_a_q < CW'(MAX_DIGITS))) begin
          a_d     = push_digit(a_q, dval);
          cnt_a_d = cnt_a_q + CW'(1);
        end else if (op_ev) begin
          state_d = S_B;
          op_d    = OP_ADD;
          b_d     = '0;
          cnt_b_d = '0;
        end
      end
      S_B: begin
        if (key_digit) begin
          if (cnt_b_q < CW'(MAX_DIGITS)) begin
            b_d     = push_digit(b_q, dval);
            cnt_b_d = cnt_b_q + CW'(1);
          end
        end else if (key_equals) begin
          state_d  = S_CALC;
          acc_d    = '0;
          mcand_d  = RW'(a_q);
          mplier_d = b_q;
          mcnt_d   = '0;
        end else if (op_ev && (cnt_b_q == '0)) begin
          op_d = (op_q == OP_MUL) ? OP_ADD : op_q + 2'd1;
        end
      end
      S_CALC: begin
        if (op_q == OP_MUL) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          mcnt_d   = mcnt_q + MW'(1);
          if (mcnt_q == MW'(OPW - 1)) begin
            res_d   = acc_step;
            state_d = S_RES;
          end
        end else begin
          res_d   = (op_q == OP_SUB) ? RW'(a_q) - RW'(b_q) : RW'(a_q) + RW'(b_q);
          state_d = S_RES;
        end
      end
      S_RES: begin
        if (key_digit) begin
          state_d = S_A;
          a_d     = OPW'(dval);
          cnt_a_d = CW'(1);
          b_d     = '0;
          cnt_b_d = '0;
          op_d    = OP_ADD;
        end
      end
      default: state_d = S_A;
    endcase

    // CLEAR overrides everything, including an in-flight multiply.
    if (key_clear) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = OP_ADD;
    end

    unique case (state_d)
      S_A:     disp_d = RW'(a_d);
      S_B:     disp_d = (cnt_b_d != '0) ? RW'(b_d) : RW'(a_d);
      S_CALC:  disp_d = RW'(a_d);
      default: disp_d = res_d;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      op_q       <= OP_ADD;
      res_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mcnt_q     <= '0;
      disp_q     <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      sel_hist_q <= 1'b1;
      op_hist_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mcnt_q     <= mcnt_d;
      disp_q     <= disp_d;
      busy_q     <= (state_d == S_CALC);
      rv_q       <= (state_d == S_RES) && (state_q != S_RES);
      sel_hist_q <= btn_sel;
      op_hist_q  <= btn_op;
    end
  end

  assign disp_value   = disp_q;
  assign state        = state_q;
  assign op_code      = op_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scenario bench for calc_entry_ctrl; computed results are queued at EQUALS
// and compared when result_valid fires.
module tb_calc_entry_ctrl;

  localparam int unsigned RW = 28;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    cursor_x, cursor_y;
  logic          btn_sel, btn_op;
  logic [RW-1:0] disp_value;
  logic [1:0]    state, op_code;
  logic          busy, result_valid;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int rv_cnt = 0;
  logic [RW-1:0] sb_q[$];

  calc_entry_ctrl #(.MAX_DIGITS(4), .OPW(14), .RW(RW)) dut (
    .clk(clk), .rst(rst), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .btn_sel(btn_sel), .btn_op(btn_op), .disp_value(disp_value),
    .state(state), .op_code(op_code), .busy(busy), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Result monitor: pops the scoreboard on every result_valid pulse.
  always @(negedge clk) begin
    logic [RW-1:0] exp_v;
    if (!rst) begin
      if (busy) busy_cnt++;
      if (result_valid) begin
        rv_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got result_valid with disp_value=%0d, expected no result", $signed(disp_value));
        end else begin
          exp_v = sb_q.pop_front();
          if (disp_value !== exp_v) begin
            errors++;
            $display("FAIL result_value: got %0d (0x%07h), expected %0d (0x%07h)",
                     $signed(disp_value), disp_value, $signed(exp_v), exp_v);
          end
        end
      end
    end
  end

  task automatic press_key(input int x, input int y);
    cursor_x = 4'(x);
    cursor_y = 4'(y);
    btn_sel  = 1'b0;
    @(negedge clk);
    btn_sel = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_op();
    btn_op = 1'b0;
    @(negedge clk);
    btn_op = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_res(input string name, input int budget);
    int n;
    n = 0;
    while (state !== 2'd3 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL %s_timeout: state=%0d after %0d cycles, expected 3", name, state, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({state, op_code, busy, result_valid} !== 6'b0 || disp_value !== '0) begin
      errors++;
      $display("FAIL reset_state: state=%0d op=%0d busy=%b rv=%b disp=%0d, expected all zero",
               state, op_code, busy, result_valid, disp_value);
    end
  endtask

  task automatic test_digit_entry();
    press_key(1, 0);
    press_key(2, 0);
    checks++;
    if (state !== 2'd0 || disp_value !== 28'd23) begin
      errors++;
      $display("FAIL digits_23: state=%0d disp=%0d, expected state=0 disp=23", state, disp_value);
    end
    repeat (3) press_key(0, 0);
    checks++;
    if (disp_value !== 28'd2311) begin
      errors++;
      $display("FAIL digit_limit: disp=%0d, expected 2311", disp_value);
    end
    press_key(0, 3);
    checks++;
    if (disp_value !== '0 || state !== 2'd0) begin
      errors++;
      $display("FAIL clear_in_a: disp=%0d state=%0d, expected 0/0", disp_value, state);
    end
  endtask

  task automatic test_add();
    press_key(0, 0);
    press_key(1, 0);
    press_op();
    checks++;
    if (state !== 2'd1 || disp_value !== 28'd12 || op_code !== 2'd0) begin
      errors++;
      $display("FAIL add_enter_b: state=%0d disp=%0d op=%0d, expected 1/12/0", state, disp_value, op_code);
    end
    press_key(2, 0);
    press_key(1, 3);
    checks++;
    if (disp_value !== 28'd30) begin
      errors++;
      $display("FAIL add_operand_b: disp=%0d, expected 30", disp_value);
    end
    busy_cnt = 0;
    rv_cnt   = 0;
    sb_q.push_back(28'd42);
    press_key(2, 3);
    wait_res("add", 10);
    checks++;
    if (busy_cnt != 1 || rv_cnt != 1 || disp_value !== 28'd42) begin
      errors++;
      $display("FAIL add_result: busy_cycles=%0d rv_pulses=%0d disp=%0d, expected 1/1/42", busy_cnt, rv_cnt, disp_value);
    end
    press_op();
    press_key(2, 3);
    checks++;
    if (state !== 2'd3 || rv_cnt != 1) begin
      errors++;
      $display("FAIL res_no_chain: state=%0d rv_pulses=%0d, expected 3/1", state, rv_cnt);
    end
    press_key(1, 2);
    checks++;
    if (state !== 2'd0 || disp_value !== 28'd8 || op_code !== 2'd0) begin
      errors++;
      $display("FAIL res_new_digit: state=%0d disp=%0d op=%0d, expected 0/8/0", state, disp_value, op_code);
    end
  endtask

  task automatic test_sub();
    press_key(0, 3);
    press_key(1, 1);
    press_op();
    press_op();
    checks++;
    if (op_code !== 2'd1 || disp_value !== 28'd5) begin
      errors++;
      $display("FAIL sub_select: op=%0d disp=%0d, expected 1/5", op_code, disp_value);
    end
    press_key(2, 2);
    press_op();
    checks++;
    if (op_code !== 2'd1) begin
      errors++;
      $display("FAIL op_locked: op=%0d, expected 1", op_code);
    end
    sb_q.push_back(28'hFFFFFFC);
    press_key(2, 3);
    wait_res("sub", 10);
    checks++;
    if (disp_value !== 28'hFFFFFFC || op_code !== 2'd1) begin
      errors++;
      $display("FAIL sub_result: disp=0x%07h op=%0d, expected 0xffffffc/1", disp_value, op_code);
    end
  endtask

  task automatic enter_mul_9999();
    press_key(0, 3);
    repeat (4) press_key(2, 2);
    repeat (3) press_op();
    repeat (4) press_key(2, 2);
  endtask

  task automatic test_mul();
    enter_mul_9999();
    checks++;
    if (op_code !== 2'd2 || disp_value !== 28'd9999) begin
      errors++;
      $display("FAIL mul_setup: op=%0d disp=%0d, expected 2/9999", op_code, disp_value);
    end
    busy_cnt = 0;
    rv_cnt   = 0;
    sb_q.push_back(28'd99980001);
    press_key(2, 3);
    wait_res("mul", 40);
    checks++;
    if (busy_cnt != 14 || rv_cnt != 1 || disp_value !== 28'd99980001) begin
      errors++;
      $display("FAIL mul_result: busy_cycles=%0d rv_pulses=%0d disp=%0d, expected 14/1/99980001", busy_cnt, rv_cnt, disp_value);
    end
  endtask

  task automatic test_clear_mid_mul();
    int n;
    enter_mul_9999();
    rv_cnt   = 0;
    n        = 0;
    cursor_x = 4'd2;
    cursor_y = 4'd3;
    btn_sel  = 1'b0;
    for (int i = 0; i < 30 && n < 5; i++) begin
      @(negedge clk);
      btn_sel = 1'b1;
      if (busy) n++;
    end
    cursor_x = 4'd0;
    cursor_y = 4'd3;
    btn_sel  = 1'b0;
    @(negedge clk);
    checks++;
    if (n != 5 || state !== 2'd0 || disp_value !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_mid_mul: busy_seen=%0d state=%0d disp=%0d busy=%b, expected 5/0/0/0", n, state, disp_value, busy);
    end
    btn_sel = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rv_cnt != 0 || state !== 2'd0) begin
      errors++;
      $display("FAIL clear_no_result: rv_pulses=%0d state=%0d, expected 0/0", rv_cnt, state);
    end
    cursor_x = 4'd0;
    cursor_y = 4'd1;
    btn_sel  = 1'b0;
    repeat (20) @(negedge clk);
    btn_sel = 1'b1;
    @(negedge clk);
    checks++;
    if (disp_value !== 28'd4 || state !== 2'd0) begin
      errors++;
      $display("FAIL held_select: disp=%0d state=%0d, expected 4/0", disp_value, state);
    end
  endtask

  task automatic test_simultaneous();
    press_key(0, 3);
    cursor_x = 4'd0;
    cursor_y = 4'd2;
    btn_sel  = 1'b0;
    btn_op   = 1'b0;
    @(negedge clk);
    btn_sel = 1'b1;
    btn_op  = 1'b1;
    @(negedge clk);
    checks++;
    if (disp_value !== 28'd7 || state !== 2'd0) begin
      errors++;
      $display("FAIL simultaneous: disp=%0d state=%0d, expected 7/0", disp_value, state);
    end
    press_key(3, 1);
    press_key(1, 4);
    checks++;
    if (disp_value !== 28'd7 || state !== 2'd0) begin
      errors++;
      $display("FAIL invalid_cursor: disp=%0d state=%0d, expected 7/0", disp_value, state);
    end
  endtask

  task automatic test_async_reset();
    press_key(0, 0);
    press_op();
    press_op();
    press_key(1, 1);
    checks++;
    if (state !== 2'd1 || disp_value !== 28'd5 || op_code !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_b: state=%0d disp=%0d op=%0d, expected 1/5/1", state, disp_value, op_code);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || disp_value !== '0 || op_code !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: state=%0d disp=%0d op=%0d busy=%b, expected all zero", state, disp_value, op_code, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    cursor_x = 4'd0;
    cursor_y = 4'd0;
    btn_sel  = 1'b1;
    btn_op   = 1'b1;
    test_reset();
    test_digit_entry();
    test_add();
    test_sub();
    test_mul();
    test_clear_mid_mul();
    test_simultaneous();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
